// File: rtl/fetch_queue.sv
// Fetch-to-Decode instruction queue: FWFT circular buffer; a pushed entry is visible one cycle later.
// Backpressure: in_ready low whenever full (registered state only); flush empties it in one cycle.
module fetch_queue #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [PC_WIDTH-1:0]      in_pc,
  input  logic [INSTR_WIDTH-1:0]   in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [PC_WIDTH-1:0]      out_pc,
  output logic [INSTR_WIDTH-1:0]   out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_WIDTH-1:0]    r_pc    [DEPTH];
  logic [INSTR_WIDTH-1:0] r_instr [DEPTH];
  logic [AW-1:0]          r_rd_ptr;
  logic [AW-1:0]          r_wr_ptr;
  logic [CW-1:0]          r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Full refuses a push even when Decode pops the same cycle, keeping in_ready off the out_ready path.
  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign w_push    = in_valid & ~w_full & ~flush;
  assign w_pop     = ~w_empty & out_ready & ~flush;

  assign out_pc    = w_empty ? '0 : r_pc[r_rd_ptr];
  assign out_instr = w_empty ? '0 : r_instr[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc[r_wr_ptr]    <= in_pc;
        r_instr[r_wr_ptr] <= in_instr;
        r_wr_ptr          <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule
